logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter_if.sv | 47 ++++
 rtl/logic_unit_arbiter.sv | 138 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_arbiter_if.sv
// Handshake bundle between two requesters, the logic-unit arbiter and the result consumer.
//
// valid/ready: a transfer happens on a rising clock edge where valid and ready are both
// high. The source raises valid with its payload and must hold both unchanged until it
// sees ready. The sink's ready may depend combinationally on valid, but valid never
// depends on ready. The same rule applies to the rsp_valid/rsp_ready pair, with the
// arbiter as source and the consumer as sink.
interface logic_unit_arbiter_if #(
    parameter int W = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic [15:0]  ops_cnt;

    // Requesters and the result consumer.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, ops_cnt
    );

    // The arbiter itself.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err, ops_cnt
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a bitwise logic unit.
// One operation in flight at a time: IDLE accepts, EXEC computes, RESP holds the result.
module logic_unit_arbiter #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_unit_arbiter_if.slave  bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic         last_grant;
    logic         grant0;
    logic         grant1;
    logic         accept;
    logic         complete;

    logic [2:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         id_q;

    logic [W-1:0] res_data;
    logic         res_err;

    logic [W-1:0] rsp_data_q;
    logic         rsp_err_q;
    logic         rsp_id_q;
    logic [15:0]  ops_cnt_q;

    // Returns {err, data}; op 7 is the only illegal code.
    function automatic logic [W:0] eval_op(
        input logic [2:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        case (op)
            3'd0:    eval_op = {1'b0, a & b};
            3'd1:    eval_op = {1'b0, a | b};
            3'd2:    eval_op = {1'b0, ~a};
            3'd3:    eval_op = {1'b0, ~(a & b)};
            3'd4:    eval_op = {1'b0, ~(a | b)};
            3'd5:    eval_op = {1'b0, a ^ b};
            3'd6:    eval_op = {1'b0, ~(a ^ b)};
            default: eval_op = {1'b1, {W{1'b0}}};
        endcase
    endfunction

    // Grant is gated by rst_n so both readys stay low while reset is held,
    // even though the state register already reads IDLE.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && (state == IDLE)) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_grant) grant0 = 1'b1;
                else            grant1 = 1'b1;
            end else if (bus.req0_valid) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign accept   = grant0 | grant1;
    assign complete = (state == RESP) && bus.rsp_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operands are captured once at acceptance and never re-sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            op_q       <= 3'd0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
        end else if (accept) begin
            last_grant <= grant1;
            id_q       <= grant1;
            op_q       <= grant1 ? bus.req1_op : bus.req0_op;
            a_q        <= grant1 ? bus.req1_a  : bus.req0_a;
            b_q        <= grant1 ? bus.req1_b  : bus.req0_b;
        end
    end

    assign {res_err, res_data} = eval_op(op_q, a_q, b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data_q <= res_data;
            rsp_err_q  <= res_err;
            rsp_id_q   <= id_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ops_cnt_q <= 16'd0;
        else if (complete) ops_cnt_q <= ops_cnt_q + 16'd1;
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.ops_cnt    = ops_cnt_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: reset, single op, op sweep, contention,
// backpressure, reset in flight and counter wrap.
module tb_logic_unit_arbiter;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  dbg_state;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] exp_ops = 16'd0;
    logic [W-1:0] exp_q[$];

    logic_unit_arbiter_if #(.W(W)) bus ();

    logic_unit_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
    endtask

    // Raise valid on one requester, wait (bounded) for its ready, let the edge accept it,
    // then drop valid. Returns just after the accepting edge (FSM in EXEC).
    task automatic issue(input bit id, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output bit granted);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        granted = 1'b0;
        for (int i = 0; i < 20 && !granted; i++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) granted = 1'b1;
            else tick();
        end
        tick();
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b%b expected 00", bus.req0_ready, bus.req1_ready);
        end
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rsp_flags: got v=%b id=%b err=%b expected 0 0 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_err);
        end
        tests_run++;
        if (bus.rsp_data !== 8'h00 || bus.ops_cnt !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_data_cnt: got data=%h cnt=%h expected 00 0000",
                     bus.rsp_data, bus.ops_cnt);
        end
        tests_run++;
        if (dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        clear_inputs();
        rst_n = 1'b1;
    endtask

    // Runs right after reset release: acceptance on the very first rising edge.
    task automatic test_single_op();
        bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 8'hF0; bus.req0_b = 8'h3C;
        #1;
        tests_run++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ready: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
        end
        tick();
        bus.req0_valid = 1'b0;
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || dbg_state !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_exec: got v=%b st=%0d expected v=0 st=1", bus.rsp_valid, dbg_state);
        end
        tick();
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 8'h30 ||
            bus.rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_rsp: got v=%b id=%b data=%h err=%b expected 1 0 30 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err);
        end
        tick();
        exp_ops = 16'd1;
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.ops_cnt !== exp_ops || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_done: got v=%b cnt=%0d st=%0d expected 0 %0d 0",
                     bus.rsp_valid, bus.ops_cnt, dbg_state, exp_ops);
        end
    endtask

    task automatic test_op_sweep();
        logic [W-1:0] exp_data [8];
        bit ok;
        exp_data = '{8'h88, 8'hEE, 8'h55, 8'h77, 8'h11, 8'h66, 8'h99, 8'h00};
        for (int op = 0; op < 8; op++) begin
            issue(1'b0, 3'(op), 8'hAA, 8'hCC, ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL sweep_grant op%0d: got no ready expected ready", op);
            end
            tick();
            tests_run++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_data[op] ||
                bus.rsp_err !== (op == 7)) begin
                tests_failed++;
                $display("FAIL sweep_op%0d: got v=%b data=%h err=%b expected 1 %h %b",
                         op, bus.rsp_valid, bus.rsp_data, bus.rsp_err, exp_data[op], (op == 7));
            end
            tick();
            exp_ops = exp_ops + 16'd1;
        end
        tests_run++;
        if (bus.ops_cnt !== exp_ops) begin
            tests_failed++;
            $display("FAIL sweep_cnt: got %0d expected %0d", bus.ops_cnt, exp_ops);
        end
    endtask

    task automatic test_contention();
        int g_cyc[$];
        int g_id[$];
        int r_cyc[$];
        int r_id[$];
        bit both_seen;
        logic [W-1:0] exp_d;
        rst_n = 1'b0;
        clear_inputs();
        bus.req0_valid = 1'b1; bus.req0_op = 3'd5; bus.req0_a = 8'h0F; bus.req0_b = 8'hFF;
        bus.req1_valid = 1'b1; bus.req1_op = 3'd1; bus.req1_a = 8'h01; bus.req1_b = 8'h02;
        @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 16'd0;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(8'hF0);
            exp_q.push_back(8'h03);
        end
        both_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) both_seen = 1'b1;
            if (bus.req0_ready) begin g_cyc.push_back(c); g_id.push_back(0); end
            if (bus.req1_ready) begin g_cyc.push_back(c); g_id.push_back(1); end
            if (bus.rsp_valid) begin
                r_cyc.push_back(c);
                r_id.push_back(int'(bus.rsp_id));
                exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
                tests_run++;
                if (bus.rsp_data !== exp_d) begin
                    tests_failed++;
                    $display("FAIL cont_data cyc%0d: got %h expected %h", c, bus.rsp_data, exp_d);
                end
            end
            @(negedge clk);
        end
        clear_inputs();
        #1;
        tests_run++;
        if (both_seen) begin
            tests_failed++;
            $display("FAIL cont_two_readys: got both high expected at most one");
        end
        tests_run++;
        if (g_cyc.size() != 4 || r_cyc.size() != 4) begin
            tests_failed++;
            $display("FAIL cont_counts: got grants=%0d rsps=%0d expected 4 4", g_cyc.size(), r_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (g_id[i] != (i % 2) || r_id[i] != (i % 2)) begin
                    tests_failed++;
                    $display("FAIL cont_order%0d: got grant=%0d rsp_id=%0d expected %0d",
                             i, g_id[i], r_id[i], i % 2);
                end
                tests_run++;
                if (g_cyc[i] != 3 * i || r_cyc[i] != 3 * i + 2) begin
                    tests_failed++;
                    $display("FAIL cont_timing%0d: got grant@%0d rsp@%0d expected %0d %0d",
                             i, g_cyc[i], r_cyc[i], 3 * i, 3 * i + 2);
                end
            end
        end
        exp_ops = 16'd4;
        tests_run++;
        if (bus.ops_cnt !== exp_ops) begin
            tests_failed++;
            $display("FAIL cont_cnt: got %0d expected %0d", bus.ops_cnt, exp_ops);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        bus.rsp_ready = 1'b0;
        issue(1'b1, 3'd6, 8'h0F, 8'h33, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL bp_grant: got no ready expected ready");
        end
        bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 8'hFF; bus.req0_b = 8'h5A;
        tick();
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== 8'hC3 ||
                bus.rsp_err !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
                bus.ops_cnt !== exp_ops) begin
                tests_failed++;
                bad = 1'b1;
                $display("FAIL bp_hold cyc%0d: got v=%b id=%b data=%h rdy=%b%b cnt=%0d expected 1 1 c3 00 %0d",
                         c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req0_ready,
                         bus.req1_ready, bus.ops_cnt, exp_ops);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || dbg_state !== 2'd2) begin
            tests_failed++;
            $display("FAIL bp_release: got v=%b st=%0d expected 1 2", bus.rsp_valid, dbg_state);
        end
        tick();
        exp_ops = exp_ops + 16'd1;
        tests_run++;
        if (bus.ops_cnt !== exp_ops || dbg_state !== 2'd0 || bus.req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_complete: got cnt=%0d st=%0d rdy0=%b expected %0d 0 1",
                     bus.ops_cnt, dbg_state, bus.req0_ready, exp_ops);
        end
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL bp_waiter: got v=%b id=%b data=%h expected 1 0 5a",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        tick();
        exp_ops = exp_ops + 16'd1;
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        bit seen;
        issue(1'b0, 3'd1, 8'h0F, 8'hF0, ok);
        bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 8'h3C; bus.req0_b = 8'h0F;
        bus.req1_valid = 1'b1; bus.req1_op = 3'd1; bus.req1_a = 8'h11; bus.req1_b = 8'h22;
        tests_run++;
        if (!ok || dbg_state !== 2'd1 || bus.ops_cnt !== exp_ops) begin
            tests_failed++;
            $display("FAIL rmid_setup: got ok=%b st=%0d cnt=%0d expected 1 1 %0d",
                     ok, dbg_state, bus.ops_cnt, exp_ops);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 8'h00 ||
            bus.rsp_err !== 1'b0 || bus.ops_cnt !== 16'd0 || bus.req0_ready !== 1'b0 ||
            bus.req1_ready !== 1'b0 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL rmid_async: got v=%b id=%b data=%h err=%b cnt=%0d rdy=%b%b st=%0d expected all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.ops_cnt,
                     bus.req0_ready, bus.req1_ready, dbg_state);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 16'd0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.rsp_valid !== 1'b0 || bus.ops_cnt !== 16'd0) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL rmid_no_rsp: got response after reset expected none");
        end
        bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 8'h3C; bus.req0_b = 8'h0F;
        bus.req1_valid = 1'b1; bus.req1_op = 3'd1; bus.req1_a = 8'h11; bus.req1_b = 8'h22;
        #1;
        tests_run++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_grant: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
        end
        tick();
        clear_inputs();
        tick();
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 8'h0C) begin
            tests_failed++;
            $display("FAIL rmid_rsp: got v=%b id=%b data=%h expected 1 0 0c",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        tick();
        exp_ops = 16'd1;
    endtask

    task automatic test_wrap();
        bit ok;
        force dut.ops_cnt_q = 16'hFFFF;
        tick();
        release dut.ops_cnt_q;
        #1;
        tests_run++;
        if (bus.ops_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL wrap_preload: got %h expected ffff", bus.ops_cnt);
        end
        issue(1'b1, 3'd2, 8'h0F, 8'h00, ok);
        tick();
        tests_run++;
        if (!ok || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== 8'hF0) begin
            tests_failed++;
            $display("FAIL wrap_rsp: got ok=%b v=%b id=%b data=%h expected 1 1 1 f0",
                     ok, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
        tick();
        tests_run++;
        if (bus.ops_cnt !== 16'h0000) begin
            tests_failed++;
            $display("FAIL wrap_cnt: got %h expected 0000", bus.ops_cnt);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_op();
        test_op_sweep();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
